// File: rtl/mask_share_gen.sv
// Two-share masking front end: splits operands A/B into Boolean shares using a 32-bit Galois LFSR.
// Optional runtime reseed port is enabled by defining MASK_SHARE_GEN_RESEED_EN.
module mask_share_gen #(
    parameter logic [31:0] SEED_DEFAULT  = 32'h1D87_2B41,
    parameter int          WARMUP_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
`ifdef MASK_SHARE_GEN_RESEED_EN
    input  logic        seed_valid,
    input  logic [31:0] seed_data,
`endif
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_A,
    input  logic        in_B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        o_A0,
    output logic        o_A1,
    output logic        o_B0,
    output logic        o_B1,
    output logic        o_rN,
    output logic [15:0] tx_count
);

    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
    localparam logic [5:0]  WARM_LAST = 6'(WARMUP_CYCLES - 1);

    typedef enum logic {WARM, RUN} state_t;

    state_t      state_reg, state_next;
    logic [31:0] lfsr_reg;
    logic [31:0] lfsr_stage [0:3];
    logic [5:0]  warm_cnt_reg;
    logic        out_valid_reg;
    logic        a0_reg, a1_reg, b0_reg, b1_reg, rn_reg;
    logic [15:0] tx_count_reg;
    logic        reseed;
    logic [31:0] seed_load;
    logic        accept;

`ifdef MASK_SHARE_GEN_RESEED_EN
    assign reseed    = seed_valid;
    assign seed_load = (seed_data == 32'd0) ? SEED_DEFAULT : seed_data;
`else
    assign reseed    = 1'b0;
    assign seed_load = SEED_DEFAULT;
`endif

    // Three Galois steps per cycle, unrolled so every cycle consumes fresh bits.
    assign lfsr_stage[0] = lfsr_reg;
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_step
            assign lfsr_stage[gi+1] = {1'b0, lfsr_stage[gi][31:1]}
                                    ^ (lfsr_stage[gi][0] ? LFSR_MASK : 32'd0);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= WARM;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (reseed) begin
            state_next = WARM;
        end else if (state_reg == WARM && warm_cnt_reg == WARM_LAST) begin
            state_next = RUN;
        end
    end

    always_comb begin
        in_ready = (state_reg == RUN) && (!out_valid_reg || out_ready) && !reseed;
    end

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_reg      <= SEED_DEFAULT;
            warm_cnt_reg  <= 6'd0;
            out_valid_reg <= 1'b0;
            a0_reg        <= 1'b0;
            a1_reg        <= 1'b0;
            b0_reg        <= 1'b0;
            b1_reg        <= 1'b0;
            rn_reg        <= 1'b0;
            tx_count_reg  <= 16'd0;
        end else begin
            lfsr_reg <= reseed ? seed_load : lfsr_stage[3];
            if (reseed) begin
                // Any held share set is discarded; masks from the old seed must not leak out.
                warm_cnt_reg  <= 6'd0;
                out_valid_reg <= 1'b0;
                a0_reg        <= 1'b0;
                a1_reg        <= 1'b0;
                b0_reg        <= 1'b0;
                b1_reg        <= 1'b0;
                rn_reg        <= 1'b0;
            end else begin
                if (state_reg == WARM && warm_cnt_reg != WARM_LAST) begin
                    warm_cnt_reg <= warm_cnt_reg + 6'd1;
                end
                if (accept) begin
                    a0_reg        <= in_A ^ lfsr_reg[0];
                    a1_reg        <= lfsr_reg[0];
                    b0_reg        <= in_B ^ lfsr_reg[1];
                    b1_reg        <= lfsr_reg[1];
                    rn_reg        <= lfsr_reg[2];
                    out_valid_reg <= 1'b1;
                    if (tx_count_reg != 16'hFFFF) begin
                        tx_count_reg <= tx_count_reg + 16'd1;
                    end
                end else if (out_ready) begin
                    out_valid_reg <= 1'b0;
                end
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign o_A0      = a0_reg;
    assign o_A1      = a1_reg;
    assign o_B0      = b0_reg;
    assign o_B1      = b1_reg;
    assign o_rN      = rn_reg;
    assign tx_count  = tx_count_reg;

endmodule

// File: tb/tb_mask_share_gen.sv
// Directed bench for mask_share_gen: warm-up, handshake, share recombination, LFSR masks, saturation.
module tb_mask_share_gen;

    localparam logic [31:0] SEED = 32'h1D87_2B41;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_A = 1'b0;
    logic        in_B = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        o_A0, o_A1, o_B0, o_B1, o_rN;
    logic [15:0] tx_count;
`ifdef MASK_SHARE_GEN_RESEED_EN
    logic        seed_valid = 1'b0;
    logic [31:0] seed_data = 32'd0;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m_lfsr;
    logic [4:0]  sb [$];

    mask_share_gen dut (
        .clk       (clk),
        .rst       (rst),
`ifdef MASK_SHARE_GEN_RESEED_EN
        .seed_valid(seed_valid),
        .seed_data (seed_data),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_A      (in_A),
        .in_B      (in_B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o_A0      (o_A0),
        .o_A1      (o_A1),
        .o_B0      (o_B0),
        .o_B1      (o_B1),
        .o_rN      (o_rN),
        .tx_count  (tx_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] galois3(input logic [31:0] s);
        logic [31:0] t;
        t = s;
        for (int k = 0; k < 3; k++) begin
            if (t[0]) t = (t >> 1) ^ 32'h8020_0003;
            else      t = t >> 1;
        end
        return t;
    endfunction

    // Reference LFSR tracking the DUT's state edge by edge.
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= SEED;
`ifdef MASK_SHARE_GEN_RESEED_EN
        else if (seed_valid) m_lfsr <= (seed_data == 32'd0) ? SEED : seed_data;
`endif
        else m_lfsr <= galois3(m_lfsr);
    end

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_run(output int cycles);
        cycles = 0;
        #1;
        while (!in_ready && cycles < 200) begin
            @(negedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        vectors++;
        if ({out_valid, in_ready, o_A0, o_A1, o_B0, o_B1, o_rN} !== 7'd0 || tx_count !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_state got ov=%b ir=%b sh=%b%b%b%b%b tx=%h want all 0",
                     out_valid, in_ready, o_A0, o_A1, o_B0, o_B1, o_rN, tx_count);
        end
    endtask

    task automatic test_warmup();
        int cyc;
        logic [2:0] m;
        @(negedge clk);
        in_valid = 1'b1; in_A = 1'b1; in_B = 1'b0; out_ready = 1'b1;
        rst = 1'b0;
        wait_run(cyc);
        vectors++;
        if (cyc !== 16) begin
            miscompares++;
            $display("FAIL warmup_len got %0d cycles want 16", cyc);
        end
        m = m_lfsr[2:0];
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        vectors++;
        if ({out_valid, o_A0 ^ o_A1, o_B0 ^ o_B1, o_A1, o_B1, o_rN} !== {1'b1, 1'b1, 1'b0, m[0], m[1], m[2]}
            || tx_count !== 16'd1) begin
            miscompares++;
            $display("FAIL first_xfer got ov=%b A=%b B=%b m=%b%b%b tx=%0d want ov=1 A=1 B=0 m=%b%b%b tx=1",
                     out_valid, o_A0 ^ o_A1, o_B0 ^ o_B1, o_A1, o_B1, o_rN, tx_count, m[0], m[1], m[2]);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        logic [4:0] snap;
        do_reset();
        in_valid = 1'b1; in_A = 1'b0; in_B = 1'b1; out_ready = 1'b0;
        wait_run(cyc);
        @(negedge clk);
        #1;
        snap = {o_A0, o_A1, o_B0, o_B1, o_rN};
        vectors++;
        if (out_valid !== 1'b1 || (o_A0 ^ o_A1) !== 1'b0 || (o_B0 ^ o_B1) !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_first got ov=%b A=%b B=%b want ov=1 A=0 B=1", out_valid, o_A0 ^ o_A1, o_B0 ^ o_B1);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {o_A0, o_A1, o_B0, o_B1, o_rN} !== snap
                || tx_count !== 16'd1) begin
                miscompares++;
                $display("FAIL bp_hold[%0d] got ov=%b ir=%b sh=%b tx=%0d want ov=1 ir=0 sh=%b tx=1",
                         k, out_valid, in_ready, {o_A0, o_A1, o_B0, o_B1, o_rN}, tx_count, snap);
            end
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0 || tx_count !== 16'd1) begin
            miscompares++;
            $display("FAIL bp_release got ov=%b tx=%0d want ov=0 tx=1", out_valid, tx_count);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        in_valid = 1'b1; in_A = 1'b1; in_B = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({out_valid, in_ready, o_A0, o_A1, o_B0, o_B1, o_rN} !== 7'd0 || tx_count !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_mid got ov=%b ir=%b sh=%b%b%b%b%b tx=%h want all 0",
                     out_valid, in_ready, o_A0, o_A1, o_B0, o_B1, o_rN, tx_count);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_stream(input int n, input bit random_ready);
        int cyc, pushed, guard;
        logic [4:0] exp;
        sb.delete();
        do_reset();
        wait_run(cyc);
        pushed = 0;
        guard = 0;
        while ((pushed < n || sb.size() != 0) && guard < 20000) begin
            @(negedge clk);
            in_valid  = (pushed < n) && (!random_ready || $urandom_range(0, 3) != 0);
            in_A      = 1'($urandom);
            in_B      = 1'($urandom);
            out_ready = !random_ready || 1'($urandom);
            #1;
            if (out_valid && out_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL stream_dup got extra share set %b want none",
                             {o_A0 ^ o_A1, o_B0 ^ o_B1, o_A1, o_B1, o_rN});
                end else begin
                    exp = sb.pop_front();
                    if ({o_A0 ^ o_A1, o_B0 ^ o_B1, o_A1, o_B1, o_rN} !== exp) begin
                        miscompares++;
                        $display("FAIL stream_data got AB/mA/mB/rN=%b want %b",
                                 {o_A0 ^ o_A1, o_B0 ^ o_B1, o_A1, o_B1, o_rN}, exp);
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back({in_A, in_B, m_lfsr[0], m_lfsr[1], m_lfsr[2]});
                pushed++;
            end
            guard++;
        end
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        vectors++;
        if (tx_count !== 16'(n) || sb.size() != 0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_end got tx=%0d left=%0d ov=%b want tx=%0d left=0 ov=0",
                     tx_count, sb.size(), out_valid, n);
        end
    endtask

`ifdef MASK_SHARE_GEN_RESEED_EN
    task automatic test_reseed();
        int cyc;
        logic [2:0] m;
        do_reset();
        in_valid = 1'b1; in_A = 1'b1; in_B = 1'b1; out_ready = 1'b0;
        wait_run(cyc);
        @(negedge clk);
        seed_valid = 1'b1; seed_data = 32'd0;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reseed_block got in_ready=%b want 0", in_ready);
        end
        @(negedge clk);
        seed_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || tx_count !== 16'd1 || m_lfsr !== SEED) begin
            miscompares++;
            $display("FAIL reseed_state got ov=%b tx=%0d want ov=0 tx=1", out_valid, tx_count);
        end
        wait_run(cyc);
        vectors++;
        if (cyc !== 16) begin
            miscompares++;
            $display("FAIL reseed_warm got %0d cycles want 16", cyc);
        end
        m = m_lfsr[2:0];
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        vectors++;
        if ({o_A1, o_B1, o_rN} !== {m[0], m[1], m[2]} || (o_A0 ^ o_A1) !== 1'b1) begin
            miscompares++;
            $display("FAIL reseed_mask got m=%b%b%b want %b%b%b", o_A1, o_B1, o_rN, m[0], m[1], m[2]);
        end
    endtask
`endif

    task automatic test_saturation();
        int cyc;
        do_reset();
        in_valid = 1'b1; in_A = 1'b0; in_B = 1'b0; out_ready = 1'b1;
        wait_run(cyc);
        for (int i = 1; i <= 65537; i++) begin
            @(negedge clk);
            if (i == 65537) in_valid = 1'b0;
            #1;
            if (i == 65534) begin
                vectors++;
                if (tx_count !== 16'hFFFE) begin
                    miscompares++;
                    $display("FAIL sat_pre got tx=%h want FFFE", tx_count);
                end
            end
        end
        vectors++;
        if (tx_count !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL sat_hit got tx=%h want FFFF", tx_count);
        end
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (tx_count !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL sat_hold got tx=%h want FFFF", tx_count);
        end
    endtask

    initial begin
        test_reset();
        test_warmup();
        test_backpressure();
        test_reset_mid();
        test_stream(1000, 1'b1);
        test_stream(200, 1'b0);
`ifdef MASK_SHARE_GEN_RESEED_EN
        test_reseed();
`endif
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
